ifetch_bridge: RTL

Instruction-fetch bridge that sits directly upstream of the RISC-V top level. It serves fetches whose PC lies in external space (pc[31]=1) and produces the instr / valid / valid_reg inputs the core consumes. It turns the core PC into a single-outstanding request/grant/response transaction on an external instruction-memory port. It holds each returned word stable while the PC stays on it, and substitutes a NOP with a sticky error flag if memory never answers.

---
 rtl/ifetch_bridge_if.sv | 25 ++
 rtl/ifetch_bridge.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_bridge_if.sv
// Instruction-memory request/grant/response bus between ifetch_bridge (master)
// and an external instruction memory (slave).
interface ifetch_bridge_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: turns the core PC into single-outstanding fetches on an
// external memory port, holds the returned word, and substitutes a NOP on timeout.
module ifetch_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            i_pc,
    ifetch_bridge_if.master        mem,
    output logic [31:0]            o_instr,
    output logic                   o_valid,
    output logic                   o_valid_reg,
    output logic                   o_fetch_err
);

    localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrain
    } state_e;

    state_e      r_state,     w_state_d;
    logic [31:0] r_req_addr,  w_req_addr_d;
    logic        r_mem_req,   w_mem_req_d;
    logic [29:0] r_tag_addr,  w_tag_addr_d;
    logic        r_tag_v,     w_tag_v_d;
    logic [15:0] r_cnt,       w_cnt_d;
    logic [31:0] r_instr,     w_instr_d;
    logic        r_valid,     w_valid_d;
    logic        r_valid_reg;
    logic        r_fetch_err, w_fetch_err_d;

    logic        w_pc_ext;
    logic [29:0] w_pc_word;
    logic        w_hit;
    logic        w_pc_at_req;
    logic        w_unused_pc;

    assign w_pc_ext    = i_pc[31];
    assign w_pc_word   = i_pc[31:2];
    assign w_unused_pc = ^i_pc[1:0];
    assign w_hit       = w_pc_ext & r_tag_v & (w_pc_word == r_tag_addr);
    assign w_pc_at_req = (w_pc_word == r_req_addr[31:2]);

    always_comb begin
        w_state_d     = r_state;
        w_req_addr_d  = r_req_addr;
        w_tag_addr_d  = r_tag_addr;
        w_tag_v_d     = r_tag_v;
        w_cnt_d       = r_cnt;
        w_instr_d     = r_instr;
        w_fetch_err_d = r_fetch_err;

        case (r_state)
            StIdle: begin
                if (w_pc_ext) begin
                    if (w_hit) begin
                        w_state_d = StHold;
                    end else begin
                        w_req_addr_d = {w_pc_word, 2'b00};
                        w_state_d    = StReq;
                    end
                end
            end
            StReq: begin
                // The request is never withdrawn; a moved pc is dealt with after the response.
                if (mem.mem_gnt) begin
                    w_cnt_d   = '0;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    if (w_pc_at_req) begin
                        w_instr_d    = mem.mem_rdata;
                        w_tag_addr_d = r_req_addr[31:2];
                        w_tag_v_d    = 1'b1;
                        w_state_d    = StHold;
                    end else if (w_pc_ext) begin
                        w_req_addr_d = {w_pc_word, 2'b00};
                        w_state_d    = StReq;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (r_cnt == LastCnt) begin
                    w_instr_d     = NOP;
                    w_tag_addr_d  = r_req_addr[31:2];
                    w_tag_v_d     = 1'b1;
                    w_fetch_err_d = 1'b1;
                    w_cnt_d       = '0;
                    w_state_d     = StDrain;
                end else begin
                    w_cnt_d = r_cnt + 16'd1;
                end
            end
            StDrain: begin
                // Swallow the late response (if any) so only one transaction is ever in flight.
                if (mem.mem_rvalid || (r_cnt == LastCnt)) begin
                    w_state_d = StHold;
                end else begin
                    w_cnt_d = r_cnt + 16'd1;
                end
            end
            StHold: begin
                if (!w_hit) begin
                    if (w_pc_ext) begin
                        w_tag_v_d    = 1'b0;
                        w_req_addr_d = {w_pc_word, 2'b00};
                        w_state_d    = StReq;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_mem_req_d = (w_state_d == StReq);
        w_valid_d   = ((w_state_d == StHold) || (w_state_d == StDrain)) & w_pc_ext & w_tag_v_d
                      & (w_pc_word == w_tag_addr_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_req_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_tag_addr  <= '0;
            r_tag_v     <= 1'b0;
            r_cnt       <= '0;
            r_instr     <= NOP;
            r_valid     <= 1'b0;
            r_valid_reg <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_req_addr  <= w_req_addr_d;
            r_mem_req   <= w_mem_req_d;
            r_tag_addr  <= w_tag_addr_d;
            r_tag_v     <= w_tag_v_d;
            r_cnt       <= w_cnt_d;
            r_instr     <= w_instr_d;
            r_valid     <= w_valid_d;
            r_valid_reg <= r_valid;
            r_fetch_err <= w_fetch_err_d;
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_req_addr;
    assign o_instr      = r_instr;
    assign o_valid      = r_valid;
    assign o_valid_reg  = r_valid_reg;
    assign o_fetch_err  = r_fetch_err;

endmodule
